// File: rtl/tl_mem_responder.sv
// Single-beat TileLink-UL memory responder: one outstanding A request, fixed LATENCY, word-addressed store.
// Optional request checking is enabled with the TL_MEM_ERR_CHECK_EN macro.
module tl_mem_responder #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int MEM_WORDS = 4096,
   parameter int LATENCY   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [2:0]        a_opcode_i,
   input  logic [2:0]        a_param_i,
   input  logic [2:0]        a_size_i,
   input  logic [3:0]        a_source_i,
   input  logic [ADDR_W-1:0] a_address_i,
   input  logic [7:0]        a_mask_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic              a_valid_i,
   output logic              a_ready_o,
   output logic [2:0]        d_opcode_o,
   output logic [1:0]        d_param_o,
   output logic [2:0]        d_size_o,
   output logic [3:0]        d_source_o,
   output logic [1:0]        d_sink_o,
   output logic              d_denied_o,
   output logic [DATA_W-1:0] d_data_o,
   output logic              d_corrupt_o,
   output logic              d_valid_o,
   input  logic              d_ready_i
);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t            state_r, state_s;
   logic [3:0]        cnt_r, cnt_s;
   logic              accept_s, hs_s, a_ready_s, d_valid_s;
   logic              err_s, is_put_s, is_get_s;
   logic              a_ready_r, d_valid_r, d_denied_r, d_corrupt_r;
   logic [2:0]        d_opcode_r, d_size_r;
   logic [3:0]        d_source_r;
   logic [DATA_W-1:0] d_data_r;
   logic [IDX_W-1:0]  idx_s;
   logic [DATA_W-1:0] mem_r [MEM_WORDS];
   logic              unused_s;

   assign idx_s    = a_address_i[3 +: IDX_W];
   assign is_put_s = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1);
   assign unused_s = ^{a_param_i, a_address_i};

`ifdef TL_MEM_ERR_CHECK_EN
   // Low address bits that must be zero for a naturally aligned access of 2^size bytes.
   function automatic logic [2:0] align_bits(input logic [2:0] size);
      case (size)
         3'd0:    align_bits = 3'b000;
         3'd1:    align_bits = 3'b001;
         3'd2:    align_bits = 3'b011;
         default: align_bits = 3'b111;
      endcase
   endfunction

   // Byte lanes covered by an aligned access of 2^size bytes at byte offset off.
   function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
      case (size)
         3'd0:    lane_mask = 8'h01 << off;
         3'd1:    lane_mask = 8'h03 << off;
         3'd2:    lane_mask = 8'h0F << off;
         default: lane_mask = 8'hFF;
      endcase
   endfunction

   assign is_get_s = (a_opcode_i == 3'd4);

   // Classify the presented request; first failing rule wins.
   always_comb begin
      err_s = 1'b0;
      if (!(is_put_s || is_get_s)) begin
         err_s = 1'b1;
      end else if (a_size_i > 3'd3) begin
         err_s = 1'b1;
      end else if ((a_address_i[2:0] & align_bits(a_size_i)) != 3'd0) begin
         err_s = 1'b1;
      end else if ((a_address_i >> (IDX_W + 3)) != {ADDR_W{1'b0}}) begin
         err_s = 1'b1;
      end else if ((a_opcode_i == 3'd0) && (a_mask_i != lane_mask(a_size_i, a_address_i[2:0]))) begin
         err_s = 1'b1;
      end else begin
         err_s = 1'b0;
      end
   end
`else
   // Without checking every non-Put opcode reads, and the index wraps naturally.
   assign is_get_s = !is_put_s;
   assign err_s    = 1'b0;
`endif

   // Next-state and next-output logic for the handshake FSM.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      accept_s = 1'b0;
      hs_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (a_valid_i && a_ready_r) begin
               accept_s = 1'b1;
               if (LATENCY == 1) begin
                  state_s = RESP;
               end else begin
                  state_s = WAIT;
                  cnt_s   = LAT_M1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 4'd1) begin
               state_s = RESP;
               cnt_s   = 4'd0;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         RESP: begin
            if (d_valid_r && d_ready_i) begin
               hs_s    = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
      // RESP is entered one edge early so d_valid appears exactly LATENCY edges after acceptance.
      a_ready_s = (state_s == IDLE);
      d_valid_s = (state_r == RESP) && !hs_s;
   end

   // State, handshake outputs and captured D fields.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         a_ready_r   <= 1'b0;
         d_valid_r   <= 1'b0;
         d_opcode_r  <= 3'd0;
         d_size_r    <= 3'd0;
         d_source_r  <= 4'd0;
         d_denied_r  <= 1'b0;
         d_corrupt_r <= 1'b0;
         d_data_r    <= {DATA_W{1'b0}};
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         a_ready_r <= a_ready_s;
         d_valid_r <= d_valid_s;
         if (accept_s) begin
            d_opcode_r  <= is_get_s ? 3'd1 : 3'd0;
            d_size_r    <= a_size_i;
            d_source_r  <= a_source_i;
            d_denied_r  <= err_s;
            d_corrupt_r <= err_s && is_get_s;
            d_data_r    <= (is_get_s && !err_s) ? mem_r[idx_s] : {DATA_W{1'b0}};
         end
      end
   end

   // Byte-masked storage write at the acceptance edge; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && accept_s && is_put_s && !err_s) begin
         for (int k = 0; k < 8; k++) begin
            if (a_mask_i[k]) begin
               mem_r[idx_s][8*k +: 8] <= a_data_i[8*k +: 8];
            end
         end
      end
   end

   assign a_ready_o   = a_ready_r;
   assign d_valid_o   = d_valid_r;
   assign d_opcode_o  = d_opcode_r;
   assign d_param_o   = 2'd0;
   assign d_size_o    = d_size_r;
   assign d_source_o  = d_source_r;
   assign d_sink_o    = 2'd0;
   assign d_denied_o  = d_denied_r;
   assign d_corrupt_o = d_corrupt_r;
   assign d_data_o    = d_data_r;
endmodule
